// File: rtl/ctrl_sequencer.sv
// Control-state sequencer for the templeEX core: drives the 4-bit decode state,
// stretches LD/SD on memory wait, counts retired instructions and gates fetch on run.
module ctrl_sequencer #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [2:0]       op,
    input  logic             mem_ready,
    output logic [3:0]       state,
    output logic [2:0]       op_q,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic             bus_err
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    // Encodings are fixed by the decode stage and must not be reordered.
    typedef enum logic [3:0] {
        S_FETCH = 4'd0,
        S_NOR   = 4'd1,
        S_ADD   = 4'd2,
        S_LD    = 4'd3,
        S_SD    = 4'd4,
        S_SETI1 = 4'd5,
        S_SETI2 = 4'd6,
        S_JL1   = 4'd7,
        S_JL2   = 4'd8,
        S_SRL   = 4'd9,
        S_MOVE  = 4'd10,
        S_PC    = 4'd11
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                err_q, err_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        op_d    = op_q;
        done_d  = 1'b0;
        count_d = count_q;
        err_d   = err_q;
        wait_d  = wait_q;

        case (state_q)
            S_FETCH: begin
                if (run) begin
                    op_d = op;
                    case (op)
                        3'b000: state_d = S_NOR;
                        3'b001: state_d = S_ADD;
                        3'b010: state_d = S_LD;
                        3'b011: state_d = S_MOVE;
                        3'b100: state_d = S_SD;
                        3'b101: state_d = S_JL1;
                        3'b110: state_d = S_SETI1;
                        3'b111: state_d = S_SRL;
                    endcase
                end
            end
            S_NOR, S_ADD, S_SRL, S_MOVE: state_d = S_PC;
            S_LD, S_SD: begin
                if (mem_ready) begin
                    state_d = S_PC;
                    wait_d  = '0;
                end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
                    // Timeout abandons the access but still retires the instruction.
                    err_d   = 1'b1;
                    state_d = S_PC;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_SETI1: state_d = S_SETI2;
            S_SETI2: state_d = S_FETCH;
            S_JL1:   state_d = S_JL2;
            S_JL2:   state_d = S_FETCH;
            S_PC:    state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase

        // Recovery from an illegal state also lands in FETCH but must not retire.
        if (state_d == S_FETCH &&
            (state_q == S_PC || state_q == S_SETI2 || state_q == S_JL2)) begin
            done_d  = 1'b1;
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= 3'b000;
            done_q  <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            done_q  <= done_d;
            count_q <= count_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    assign state       = state_q;
    assign instr_done  = done_q;
    assign instr_count = count_q;
    assign bus_err     = err_q;

endmodule
